// File: rtl/reset_sequencer.sv
// reset_sequencer: gates a set of active-low domain resets on a filtered
// PLL lock, releases them in ascending order at programmable counter
// thresholds, and re-asserts them in reverse order on lock loss or on a
// soft re-sequence request.
`timescale 1ns / 1ps

module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned FIRST_DELAY = 32'h1FFFFF,
  parameter int unsigned STAGE_STEP  = 32'h100000,
  parameter int unsigned LOCK_FILT   = 4,
  parameter int unsigned ASSERT_GAP  = 16
) (
  input  logic                  iCLK,
  input  logic                  reset_reg,
  input  logic                  iLOCK,
  input  logic                  iSOFT_RST,
  output logic [NUM_STAGES-1:0] oRST_N,
  output logic                  oREADY
);

  localparam int unsigned LOCK_W = $clog2(LOCK_FILT + 1);
  localparam int unsigned GAP_W  = $clog2(ASSERT_GAP + 1);

  localparam logic [63:0] LAST_T  = 64'(FIRST_DELAY) + 64'(NUM_STAGES - 1) * 64'(STAGE_STEP);
  localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? '1 : ((64'd1 << CNT_W) - 64'd1);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(ASSERT_GAP - 1);

  // Parameter sanity: refuse to build a sequencer whose schedule cannot work.
  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_stages
    $error("reset_sequencer: NUM_STAGES must be in 1..16");
  end
  if (LOCK_FILT < 1) begin : g_bad_lock_filt
    $error("reset_sequencer: LOCK_FILT must be at least 1");
  end
  if (ASSERT_GAP < 1) begin : g_bad_assert_gap
    $error("reset_sequencer: ASSERT_GAP must be at least 1");
  end
  if (LAST_T > CNT_MAX) begin : g_bad_schedule
    $error("reset_sequencer: last release threshold does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK,
    COUNT_UP,
    RUN,
    SHUTDOWN
  } state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [LOCK_W-1:0]       lock_cnt, lock_cnt_d;
  logic [GAP_W-1:0]        gap_cnt, gap_cnt_d;
  logic [NUM_STAGES-1:0]   rst_n_d;
  logic                    ready_d;
  logic [NUM_STAGES-1:0]   release_mask;
  logic                    last_hit;
  logic                    abort;

  // Counter value at which stage k is released.
  function automatic logic [CNT_W-1:0] threshold(input int k);
    logic [63:0] t;
    t = 64'(FIRST_DELAY) + 64'(k) * 64'(STAGE_STEP);
    return t[CNT_W-1:0];
  endfunction

  // Stages whose release threshold matches the current count.
  always_comb begin
    release_mask = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      release_mask[k] = (cnt == threshold(k));
    end
    last_hit = (cnt == threshold(int'(NUM_STAGES) - 1));
  end

  // Next-state and next-output logic.
  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    lock_cnt_d = lock_cnt;
    gap_cnt_d  = gap_cnt;
    rst_n_d    = oRST_N;
    ready_d    = oREADY;
    abort      = !iLOCK || iSOFT_RST;

    case (state)
      WAIT_LOCK: begin
        if (!iLOCK) begin
          lock_cnt_d = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_d    = COUNT_UP;
          cnt_d      = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt + 1'b1;
        end
      end

      COUNT_UP, RUN: begin
        if (abort) begin
          // Released stages always form a low-order run of ones, so
          // dropping the highest released stage is a right shift.
          state_d   = SHUTDOWN;
          ready_d   = 1'b0;
          gap_cnt_d = '0;
          rst_n_d   = oRST_N >> 1;
        end else if (state == COUNT_UP) begin
          cnt_d   = cnt + 1'b1;
          rst_n_d = oRST_N | release_mask;
          if (last_hit) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      SHUTDOWN: begin
        if (oRST_N == '0) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
          cnt_d      = '0;
        end else if (gap_cnt == GAP_LAST) begin
          rst_n_d   = oRST_N >> 1;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = WAIT_LOCK;
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge iCLK) begin
    if (reset_reg) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      lock_cnt <= '0;
      gap_cnt  <= '0;
      oRST_N   <= '0;
      oREADY   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      lock_cnt <= lock_cnt_d;
      gap_cnt  <= gap_cnt_d;
      oRST_N   <= rst_n_d;
      oREADY   <= ready_d;
    end
  end

endmodule
